// File: rtl/usb_tx_fsm.sv
// usb_tx_fsm: USB packet transmitter (SYNC, PID, DATA, CRC16, EOP)
// with bit stuffing and NRZI line coding on registered D+/D- outputs.
module usb_tx_fsm #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [2:0] tx_packet,
  input  logic [6:0] buffer_occupancy,
  input  logic [7:0] tx_data,
  output logic       get_tx_data,
  output logic       dp_out,
  output logic       dm_out,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP_SE0, EOP_J
  } state_t;

  state_t      state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]  idx, idx_nx;
  logic [7:0]  shreg, shreg_nx;
  logic [2:0]  ptype, ptype_nx;
  logic [6:0]  count, count_nx;
  logic [2:0]  ones, ones_nx;
  logic        stuff, stuff_nx;
  logic [15:0] crc, crc_nx;
  logic        dp_nx, dm_nx;
  logic        busy_nx, done_nx, err_nx, get_nx;

  logic        bit_end, cur, valid, hshake, need_stuff;
  logic [3:0]  nib;

  assign bit_end = (cnt == LAST);
  assign cur     = shreg[0];
  assign valid   = (tx_packet != 3'd0) && (tx_packet < 3'd6);
  assign hshake  = (ptype >= 3'd3);

  // Reflected form of x^16+x^15+x^2+1, fed LSB first
  function automatic logic [15:0] crc_step(
    input logic [15:0] c,
    input logic        b
  );
    logic fb;
    fb = c[0] ^ b;
    crc_step = {1'b0, c[15:1]} ^ (fb ? 16'hA001 : 16'h0000);
  endfunction

  always_comb begin
    unique case (ptype)
      3'd1:    nib = 4'b0011;
      3'd2:    nib = 4'b1011;
      3'd3:    nib = 4'b0010;
      3'd4:    nib = 4'b1010;
      3'd5:    nib = 4'b1110;
      default: nib = 4'b0000;
    endcase
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + CW'(1);
    idx_nx     = idx;
    shreg_nx   = shreg;
    ptype_nx   = ptype;
    count_nx   = count;
    ones_nx    = ones;
    stuff_nx   = stuff;
    crc_nx     = crc;
    dp_nx      = dp_out;
    dm_nx      = dm_out;
    busy_nx    = tx_busy;
    done_nx    = 1'b0;
    err_nx     = 1'b0;
    get_nx     = 1'b0;
    need_stuff = 1'b0;

    if (state == IDLE) begin
      cnt_nx  = '0;
      dp_nx   = 1'b1;
      dm_nx   = 1'b0;
      busy_nx = 1'b0;
      if (tx_start) begin
        if (valid) begin
          state_nx = SYNC;
          shreg_nx = 8'h80;
          idx_nx   = 3'd0;
          ptype_nx = tx_packet;
          count_nx = (buffer_occupancy > 7'd64) ?
                     7'd64 : buffer_occupancy;
          ones_nx  = 3'd0;
          stuff_nx = 1'b0;
          crc_nx   = 16'hFFFF;
          busy_nx  = 1'b1;
          dp_nx    = 1'b0;
          dm_nx    = 1'b1;
        end else begin
          err_nx = 1'b1;
        end
      end
    end else if (bit_end) begin
      cnt_nx = '0;
      if (state == EOP_SE0) begin
        idx_nx = idx + 3'd1;
        if (idx == 3'd1) begin
          state_nx = EOP_J;
          dp_nx    = 1'b1;
          dm_nx    = 1'b0;
        end
      end else if (state == EOP_J) begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
        done_nx  = 1'b1;
      end else begin
        if (!stuff) begin
          ones_nx    = cur ? ones + 3'd1 : 3'd0;
          need_stuff = cur && (ones == 3'd5);
          if (state == DATA)
            crc_nx = crc_step(crc, cur);
        end else begin
          ones_nx = 3'd0;
        end

        if (need_stuff) begin
          // Stuffed zero: line toggles, pipeline holds
          stuff_nx = 1'b1;
          dp_nx    = ~dp_out;
          dm_nx    = dp_out;
        end else begin
          stuff_nx = 1'b0;
          idx_nx   = idx + 3'd1;
          shreg_nx = {1'b0, shreg[7:1]};
          if (idx == 3'd7) begin
            case (state)
              SYNC: begin
                state_nx = PID;
                shreg_nx = {~nib, nib};
              end
              PID, DATA: begin
                if (state == PID && hshake) begin
                  state_nx = EOP_SE0;
                end else if (count != 7'd0) begin
                  state_nx = DATA;
                  shreg_nx = tx_data;
                  get_nx   = 1'b1;
                  count_nx = count - 7'd1;
                end else begin
                  state_nx = CRC_LO;
                  shreg_nx = ~crc_nx[7:0];
                end
              end
              CRC_LO: begin
                state_nx = CRC_HI;
                shreg_nx = ~crc[15:8];
              end
              default: state_nx = EOP_SE0;
            endcase
          end

          if (state_nx == EOP_SE0) begin
            dp_nx = 1'b0;
            dm_nx = 1'b0;
          end else if (!shreg_nx[0]) begin
            dp_nx = ~dp_out;
            dm_nx = dp_out;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= 3'd0;
      shreg       <= 8'h00;
      ptype       <= 3'd0;
      count       <= 7'd0;
      ones        <= 3'd0;
      stuff       <= 1'b0;
      crc         <= 16'hFFFF;
      dp_out      <= 1'b1;
      dm_out      <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
      get_tx_data <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      idx         <= idx_nx;
      shreg       <= shreg_nx;
      ptype       <= ptype_nx;
      count       <= count_nx;
      ones        <= ones_nx;
      stuff       <= stuff_nx;
      crc         <= crc_nx;
      dp_out      <= dp_nx;
      dm_out      <= dm_nx;
      tx_busy     <= busy_nx;
      tx_done     <= done_nx;
      tx_error    <= err_nx;
      get_tx_data <= get_nx;
    end
  end

endmodule

// File: tb/tb_usb_tx_fsm.sv
// tb_usb_tx_fsm: bench for usb_tx_fsm; a packet-level model
// predicts the line every cycle, plus directed literal checks.
module tb_usb_tx_fsm;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [2:0] tx_packet = 3'd0;
  logic [6:0] buffer_occupancy = 7'd0;
  logic [7:0] tx_data;
  logic       get_tx_data, dp_out, dm_out;
  logic       tx_busy, tx_done, tx_error;

  int checks = 0;
  int errors = 0;
  int shown = 0;

  typedef struct packed {
    logic dp;
    logic dm;
    logic busy;
    logic done;
    logic get;
  } rec_t;

  localparam rec_t IDLE_R = 5'b10000;

  rec_t       wave[$];
  rec_t       scratch[$];
  rec_t       e = IDLE_R;
  logic       e_err = 1'b0;
  logic       check_en = 1'b0;
  logic [7:0] mem [256];
  logic [7:0] rd = 8'd0;

  usb_tx_fsm #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .n_rst(n_rst),
    .tx_start(tx_start),
    .tx_packet(tx_packet),
    .buffer_occupancy(buffer_occupancy),
    .tx_data(tx_data),
    .get_tx_data(get_tx_data),
    .dp_out(dp_out),
    .dm_out(dm_out),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .tx_error(tx_error)
  );

  always #5 clk = ~clk;

  // First-word-fall-through FIFO
  assign tx_data = mem[rd];
  always @(posedge clk)
    if (get_tx_data) rd <= rd + 8'd1;

  // CRC-16/USB, MSB-first register, result reflected and inverted
  function automatic logic [15:0] crc_usb(input logic [7:0] d[$]);
    logic [15:0] c;
    logic [15:0] r;
    c = 16'hFFFF;
    foreach (d[k])
      for (int i = 0; i < 8; i++)
        if (c[15] ^ d[k][i]) c = (c << 1) ^ 16'h8005;
        else c = c << 1;
    for (int i = 0; i < 16; i++) r[i] = c[15-i];
    return ~r;
  endfunction

  function automatic logic [7:0] pid_of(input logic [2:0] p);
    logic [3:0] n;
    case (p)
      3'd1:    n = 4'b0011;
      3'd2:    n = 4'b1011;
      3'd3:    n = 4'b0010;
      3'd4:    n = 4'b1010;
      default: n = 4'b1110;
    endcase
    return {~n, n};
  endfunction

  // Whole-packet waveform: raw bits -> stuffing -> NRZI -> EOP
  task automatic build(input logic [2:0] p, input int nb);
    logic       raw[$];
    logic       st[$];
    logic       o[$];
    logic       pop[$];
    logic [7:0] d[$];
    logic [7:0] pid;
    logic [15:0] cr;
    int         run;
    logic       lvl;
    scratch.delete();
    for (int i = 0; i < 8; i++) begin
      raw.push_back(i == 7);
      st.push_back(1'b0);
    end
    pid = pid_of(p);
    for (int i = 0; i < 8; i++) begin
      raw.push_back(pid[i]);
      st.push_back(1'b0);
    end
    if (p <= 3'd2) begin
      for (int k = 0; k < nb; k++) d.push_back(mem[8'(rd + k)]);
      foreach (d[k])
        for (int i = 0; i < 8; i++) begin
          raw.push_back(d[k][i]);
          st.push_back(i == 0);
        end
      cr = crc_usb(d);
      for (int i = 0; i < 16; i++) begin
        raw.push_back(cr[i]);
        st.push_back(1'b0);
      end
    end
    run = 0;
    foreach (raw[i]) begin
      o.push_back(raw[i]);
      pop.push_back(st[i]);
      run = raw[i] ? run + 1 : 0;
      if (run == 6) begin
        o.push_back(1'b0);
        pop.push_back(1'b0);
        run = 0;
      end
    end
    lvl = 1'b1;
    foreach (o[i]) begin
      if (!o[i]) lvl = ~lvl;
      for (int c = 0; c < CPB; c++)
        scratch.push_back('{lvl, ~lvl, 1'b1, 1'b0, pop[i] && c == 0});
    end
    for (int c = 0; c < 2 * CPB; c++) scratch.push_back(5'b00100);
    for (int c = 0; c < CPB; c++) scratch.push_back(5'b10100);
    scratch.push_back(5'b10010);
  endtask

  always @(posedge clk or negedge n_rst) begin : model
    int nb;
    if (!n_rst) begin
      wave.delete();
      e     <= IDLE_R;
      e_err <= 1'b0;
    end else begin
      e_err <= 1'b0;
      if (wave.size() > 0) begin
        e <= wave.pop_front();
      end else begin
        e <= IDLE_R;
        if (tx_start) begin
          if (tx_packet >= 3'd1 && tx_packet <= 3'd5) begin
            nb = (buffer_occupancy > 7'd64) ? 64 : int'(buffer_occupancy);
            build(tx_packet, nb);
            wave = scratch;
            e <= wave.pop_front();
          end else begin
            e_err <= 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    rec_t g;
    if (n_rst && check_en) begin
      g = '{dp_out, dm_out, tx_busy, tx_done, get_tx_data};
      checks++;
      if (g !== e || tx_error !== e_err) begin
        errors++;
        if (shown < 20) begin
          shown++;
          $display("FAIL line t=%0t got dp/dm/busy/done/get=%b err=%b want %b err=%b",
                   $time, g, tx_error, e, e_err);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic load(input logic [7:0] b[$]);
    foreach (b[k]) mem[8'(rd + k)] = b[k];
  endtask

  task automatic send(
    input  logic [2:0] p,
    input  logic [6:0] occ,
    input  int         poke_at,
    input  int         rst_at,
    output int         busy_len,
    output int         pops
  );
    int n;
    busy_len = -1;
    pops = 0;
    @(negedge clk);
    tx_packet = p;
    buffer_occupancy = occ;
    tx_start = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (get_tx_data) pops++;
      if (tx_done) begin
        busy_len = n - 1;
        break;
      end
      if (n >= 6000) break;
      if (n == rst_at) begin
        #2 n_rst = 1'b0;
        #1;
        chk("rst_dp", int'(dp_out), 1);
        chk("rst_dm", int'(dm_out), 0);
        chk("rst_busy", int'(tx_busy), 0);
        #1 n_rst = 1'b1;
        busy_len = 0;
        break;
      end
      tx_start = (n == poke_at) || (n == poke_at + 1);
      tx_packet = (n == poke_at + 1) ? 3'd6 : p;
    end
    tx_start = 1'b0;
    if (busy_len < 0) chk("done_timeout", n, -1);
  endtask

  initial begin
    int bl;
    int pc;
    logic [7:0] q[$];
    logic [7:0] none[$];
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 5);

    #1 n_rst = 1'b0;
    #2;
    chk("reset_dp", int'(dp_out), 1);
    chk("reset_dm", int'(dm_out), 0);
    chk("reset_busy", int'(tx_busy), 0);
    chk("reset_done", int'(tx_done), 0);
    chk("reset_err", int'(tx_error), 0);
    chk("reset_get", int'(get_tx_data), 0);

    q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
          8'h36, 8'h37, 8'h38, 8'h39};
    chk("crc_check", int'(crc_usb(q)), 16'hB4C8);
    chk("crc_empty", int'(crc_usb(none)), 0);
    chk("pid_ack", int'(pid_of(3'd3)), 8'hD2);
    chk("pid_data1", int'(pid_of(3'd2)), 8'h4B);
    build(3'd3, 0);
    chk("model_ack_len", scratch.size(), 153);

    @(negedge clk);
    n_rst = 1'b1;
    check_en = 1'b1;

    send(3'd3, 7'd0, 0, 0, bl, pc);
    chk("ack_busy", bl, 152);
    chk("ack_pops", pc, 0);

    send(3'd2, 7'd0, 0, 0, bl, pc);
    chk("zlp_busy", bl, 280);
    chk("zlp_pops", pc, 0);

    q = '{8'hFF};
    load(q);
    send(3'd1, 7'd1, 0, 0, bl, pc);
    chk("ff_busy", bl, 360);
    chk("ff_pops", pc, 1);

    @(negedge clk);
    tx_packet = 3'd6;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    chk("inv_err", int'(tx_error), 1);
    chk("inv_busy", int'(tx_busy), 0);
    chk("inv_dp", int'(dp_out), 1);
    @(negedge clk);
    chk("inv_err_clr", int'(tx_error), 0);

    send(3'd4, 7'd0, 40, 0, bl, pc);
    chk("nak_poke_busy", bl, 152);

    q = '{8'h01, 8'h7E, 8'h3F};
    load(q);
    send(3'd2, 7'd3, 0, 0, bl, pc);
    chk("d3_pops", pc, 3);

    send(3'd5, 7'd0, 0, 0, bl, pc);
    chk("stall_busy", bl, 152);

    send(3'd1, 7'd70, 0, 0, bl, pc);
    chk("max_pops", pc, 64);

    q = '{8'hFF, 8'hFF, 8'h12, 8'h34};
    load(q);
    send(3'd1, 7'd4, 0, 150, bl, pc);
    @(negedge clk);
    chk("post_rst_busy", int'(tx_busy), 0);

    q = '{8'hAA, 8'h55};
    load(q);
    send(3'd2, 7'd2, 0, 0, bl, pc);
    chk("after_rst_pops", pc, 2);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
